// File: rtl/stream_rr_merge_if.sv
// Handshake bundle for stream_rr_merge: start token, N input streams, merged output, completion token.
// The out0_src tag signal exists only when STREAM_MERGE_SRC_TAG_EN is defined.
interface stream_rr_merge_if #(
    parameter int N = 2,
    parameter int W = 64
);
    logic             inCtrl_valid;
    logic             inCtrl_ready;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [N*W-1:0]   in_data_field0;
    logic [N-1:0]     in_data_field1;
    logic             out0_valid;
    logic             out0_ready;
    logic [W-1:0]     out0_data_field0;
    logic             out0_data_field1;
    logic             outCtrl_valid;
    logic             outCtrl_ready;
`ifdef STREAM_MERGE_SRC_TAG_EN
    logic [$clog2(N)-1:0] out0_src;

    modport slave (
        input  inCtrl_valid, in_valid, in_data_field0, in_data_field1, out0_ready, outCtrl_ready,
        output inCtrl_ready, in_ready, out0_valid, out0_data_field0, out0_data_field1, out0_src,
               outCtrl_valid
    );
    modport master (
        output inCtrl_valid, in_valid, in_data_field0, in_data_field1, out0_ready, outCtrl_ready,
        input  inCtrl_ready, in_ready, out0_valid, out0_data_field0, out0_data_field1, out0_src,
               outCtrl_valid
    );
`else
    modport slave (
        input  inCtrl_valid, in_valid, in_data_field0, in_data_field1, out0_ready, outCtrl_ready,
        output inCtrl_ready, in_ready, out0_valid, out0_data_field0, out0_data_field1, outCtrl_valid
    );
    modport master (
        output inCtrl_valid, in_valid, in_data_field0, in_data_field1, out0_ready, outCtrl_ready,
        input  inCtrl_ready, in_ready, out0_valid, out0_data_field0, out0_data_field1, outCtrl_valid
    );
`endif
endinterface

// File: rtl/stream_rr_merge.sv
// Round-robin merge of N {data,eos} streams into one registered output, framed by start/completion tokens.
// Optional STREAM_MERGE_SRC_TAG_EN adds out0_src, the source index registered alongside each data token.
module stream_rr_merge #(
    parameter int N = 2,
    parameter int W = 64
) (
    input  logic             clock,
    input  logic             reset,
    stream_rr_merge_if.slave bus
);
    localparam int PW = $clog2(N);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_CTRL  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  done_q, done_d;
    logic          ctrl_rdy_q, ctrl_rdy_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_eos_q, out_eos_d;
`ifdef STREAM_MERGE_SRC_TAG_EN
    logic [PW-1:0] src_q, src_d;
`endif

    logic          space_s;
    logic [N-1:0]  grant_s;
    logic [PW-1:0] gnt_idx_s;
    logic [PW-1:0] scan_s;
    logic          gnt_any_s;
    logic          gnt_eos_s;
    logic [W-1:0]  gnt_data_s;

    assign space_s = !out_valid_q || bus.out0_ready;

    // Scan upward from ptr_q; the first live (not done) valid input wins, only when the register can take it.
    always_comb begin
        grant_s    = '0;
        gnt_idx_s  = '0;
        scan_s     = '0;
        gnt_any_s  = 1'b0;
        gnt_data_s = '0;
        if (state_q == ST_RUN && space_s) begin
            for (int k = 0; k < N; k++) begin
                scan_s = PW'((int'(ptr_q) + k) % N);
                if (!gnt_any_s && bus.in_valid[scan_s] && !done_q[scan_s]) begin
                    gnt_any_s        = 1'b1;
                    gnt_idx_s        = scan_s;
                    grant_s[scan_s]  = 1'b1;
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
        end else begin
            gnt_any_s = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (grant_s[k]) begin
                gnt_data_s = bus.in_data_field0[k*W +: W];
            end else begin
                gnt_data_s = gnt_data_s;
            end
        end
    end

    assign gnt_eos_s = |(grant_s & bus.in_data_field1);

    // Next state, pointer/done bookkeeping and output-register loads.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        done_d      = done_q;
        out_valid_d = out_valid_q && !bus.out0_ready;
        out_data_d  = out_data_q;
        out_eos_d   = out_eos_q;
`ifdef STREAM_MERGE_SRC_TAG_EN
        src_d       = src_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.inCtrl_valid && ctrl_rdy_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (gnt_any_s) begin
                    ptr_d = (gnt_idx_s == PW'(N - 1)) ? '0 : gnt_idx_s + 1'b1;
                    if (gnt_eos_s) begin
                        done_d = done_q | grant_s;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = gnt_data_s;
                        out_eos_d   = 1'b0;
`ifdef STREAM_MERGE_SRC_TAG_EN
                        src_d       = gnt_idx_s;
`endif
                    end
                end else begin
                    ptr_d = ptr_q;
                end
                if (&done_d) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Once the EOS sits in the register, wait for it to drain; before that, load it on any space.
                if (out_valid_q && out_eos_q) begin
                    if (bus.out0_ready) begin
                        state_d = ST_CTRL;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else if (space_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_eos_d   = 1'b1;
`ifdef STREAM_MERGE_SRC_TAG_EN
                    src_d       = '0;
`endif
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_CTRL: begin
                if (bus.outCtrl_ready) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CTRL;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        ctrl_rdy_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset discards any held token.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            done_q      <= '0;
            ctrl_rdy_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eos_q   <= 1'b0;
`ifdef STREAM_MERGE_SRC_TAG_EN
            src_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            ctrl_rdy_q  <= ctrl_rdy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eos_q   <= out_eos_d;
`ifdef STREAM_MERGE_SRC_TAG_EN
            src_q       <= src_d;
`endif
        end
    end

    assign bus.inCtrl_ready     = ctrl_rdy_q;
    assign bus.in_ready         = grant_s;
    assign bus.out0_valid       = out_valid_q;
    assign bus.out0_data_field0 = out_data_q;
    assign bus.out0_data_field1 = out_eos_q;
    assign bus.outCtrl_valid    = (state_q == ST_CTRL);
`ifdef STREAM_MERGE_SRC_TAG_EN
    assign bus.out0_src         = src_q;
`endif

endmodule

// File: tb/tb_stream_rr_merge.sv
// Bench for stream_rr_merge: an N=2 and an N=4 instance, one active at a time, checked against a
// queue-based round-robin model (exact order when inputs are always valid, per-source order otherwise).
module tb_stream_rr_merge;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stream_rr_merge_if #(.N(2), .W(W)) if2 ();
    stream_rr_merge_if #(.N(4), .W(W)) if4 ();

    stream_rr_merge #(.N(2), .W(W)) dut2 (.clock(clk), .reset(reset), .bus(if2));
    stream_rr_merge #(.N(4), .W(W)) dut4 (.clock(clk), .reset(reset), .bus(if4));

    logic         sel;
    logic [3:0]   drv_valid;
    logic [3:0]   drv_eos;
    logic [W-1:0] drv_data [4];
    logic         drv_ctrl_valid, drv_out_ready, drv_outctrl_ready;

    assign if2.inCtrl_valid   = drv_ctrl_valid && !sel;
    assign if2.in_valid       = sel ? 2'b00 : drv_valid[1:0];
    assign if2.in_data_field0 = {drv_data[1], drv_data[0]};
    assign if2.in_data_field1 = drv_eos[1:0];
    assign if2.out0_ready     = drv_out_ready;
    assign if2.outCtrl_ready  = drv_outctrl_ready;
    assign if4.inCtrl_valid   = drv_ctrl_valid && sel;
    assign if4.in_valid       = sel ? drv_valid : 4'b0000;
    assign if4.in_data_field0 = {drv_data[3], drv_data[2], drv_data[1], drv_data[0]};
    assign if4.in_data_field1 = drv_eos;
    assign if4.out0_ready     = drv_out_ready;
    assign if4.outCtrl_ready  = drv_outctrl_ready;

    logic [3:0]   obs_in_ready;
    logic         obs_out_valid, obs_out_eos, obs_ctrl_ready, obs_outctrl_valid;
    logic [W-1:0] obs_out_data;
    logic [1:0]   obs_src;
    assign obs_in_ready      = sel ? if4.in_ready : {2'b00, if2.in_ready};
    assign obs_out_valid     = sel ? if4.out0_valid : if2.out0_valid;
    assign obs_out_eos       = sel ? if4.out0_data_field1 : if2.out0_data_field1;
    assign obs_out_data      = sel ? if4.out0_data_field0 : if2.out0_data_field0;
    assign obs_ctrl_ready    = sel ? if4.inCtrl_ready : if2.inCtrl_ready;
    assign obs_outctrl_valid = sel ? if4.outCtrl_valid : if2.outCtrl_valid;
`ifdef STREAM_MERGE_SRC_TAG_EN
    assign obs_src = sel ? if4.out0_src : {1'b0, if2.out0_src};
`else
    assign obs_src = 2'b00;
`endif

    int checks = 0;
    int errors = 0;
    int ctrl_cnt, outctrl_cnt;
    int valid_pct, ready_mode;
    bit ctrl_acc, stall_pend;
    logic [3:0] acc;
    logic [W:0] stall_tok;
    logic [W:0] tok_q [4][$];
    logic [W:0] out_log[$];
    logic [1:0] src_log[$];
    int         gnt_log[$];
    logic [W:0] exp_q[$];
    int         exp_src[$];
    int         exp_gnt[$];

    task automatic push_tok(input int i, input bit eos, input logic [W-1:0] d);
        tok_q[i].push_back({eos, d});
    endtask

    // Reference: pop tokens round-robin from a copy of the input queues, assuming every input is always valid.
    task automatic build_model(input int n);
        logic [W:0] m [4][$];
        bit dn [4];
        bit all_done;
        int p, i;
        logic [W:0] t;
        exp_q.delete(); exp_src.delete(); exp_gnt.delete();
        for (int j = 0; j < 4; j++) begin
            m[j] = tok_q[j];
            dn[j] = (j >= n);
        end
        p = 0;
        for (int g = 0; g < 1000; g++) begin
            all_done = 1'b1;
            for (int j = 0; j < n; j++) if (!dn[j]) all_done = 1'b0;
            if (all_done) break;
            i = p;
            while (dn[i]) i = (i + 1) % n;
            if (m[i].size() == 0) begin
                dn[i] = 1'b1;
                continue;
            end
            t = m[i].pop_front();
            exp_gnt.push_back(i);
            if (t[W]) dn[i] = 1'b1;
            else begin
                exp_q.push_back(t);
                exp_src.push_back(i);
            end
            p = (i + 1) % n;
        end
        exp_q.push_back({1'b1, {W{1'b0}}});
        exp_src.push_back(0);
    endtask

    task automatic drive();
        if (ctrl_acc) drv_ctrl_valid = 1'b0;
        ctrl_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (drv_valid[i] && !acc[i]) begin
                drv_valid[i] = 1'b1;
            end else if (tok_q[i].size() > 0 && $urandom_range(0, 99) < valid_pct) begin
                drv_valid[i] = 1'b1;
                {drv_eos[i], drv_data[i]} = tok_q[i][0];
            end else begin
                drv_valid[i] = 1'b0;
                drv_eos[i]   = 1'($urandom_range(0, 1));
                drv_data[i]  = W'($urandom);
            end
        end
        acc = '0;
        case (ready_mode)
            0: drv_out_ready = 1'b1;
            1: drv_out_ready = !drv_out_ready;
            2: drv_out_ready = 1'($urandom_range(0, 1));
            default: drv_out_ready = 1'b0;
        endcase
        drv_outctrl_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One clock: sample just before the rising edge, then drive the next inputs on the falling edge.
    task automatic step();
        #4;
        checks++;
        if ($countones(obs_in_ready) > 1) begin
            errors++;
            $display("FAIL ready_onehot got %b required at most one bit set", obs_in_ready);
        end
        if (stall_pend) begin
            checks++;
            if (!obs_out_valid || {obs_out_eos, obs_out_data} !== stall_tok) begin
                errors++;
                $display("FAIL stall_hold got valid=%b tok=%h required valid=1 tok=%h",
                         obs_out_valid, {obs_out_eos, obs_out_data}, stall_tok);
            end
        end
        stall_pend = obs_out_valid && !drv_out_ready;
        stall_tok  = {obs_out_eos, obs_out_data};
        for (int i = 0; i < 4; i++) begin
            acc[i] = drv_valid[i] && obs_in_ready[i];
            if (acc[i]) begin
                void'(tok_q[i].pop_front());
                gnt_log.push_back(i);
            end
        end
        if (obs_out_valid && drv_out_ready) begin
            out_log.push_back({obs_out_eos, obs_out_data});
            src_log.push_back(obs_src);
        end
        if (drv_ctrl_valid && obs_ctrl_ready) begin
            ctrl_cnt++;
            ctrl_acc = 1'b1;
        end
        if (obs_outctrl_valid && drv_outctrl_ready) outctrl_cnt++;
        @(negedge clk);
        drive();
    endtask

    task automatic clear_drv();
        drv_valid = '0;
        drv_eos = '0;
        for (int i = 0; i < 4; i++) begin
            drv_data[i] = '0;
            tok_q[i].delete();
        end
        drv_ctrl_valid = 1'b0;
        drv_out_ready = 1'b1;
        drv_outctrl_ready = 1'b1;
        acc = '0;
        ctrl_acc = 1'b0;
        stall_pend = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_drv();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_stream(input int budget);
        int cyc;
        out_log.delete(); src_log.delete(); gnt_log.delete();
        ctrl_cnt = 0;
        outctrl_cnt = 0;
        drv_valid = '0;
        acc = '0;
        drv_ctrl_valid = 1'b1;
        drive();
        cyc = 0;
        while (outctrl_cnt == 0 && cyc < budget) begin
            step();
            cyc++;
        end
        repeat (4) step();
        checks++;
        if (outctrl_cnt != 1) begin
            errors++;
            $display("FAIL outctrl_count got %0d required 1 (after %0d cycles)", outctrl_cnt, cyc);
        end
        checks++;
        if (ctrl_cnt != 1) begin
            errors++;
            $display("FAIL inctrl_count got %0d required 1", ctrl_cnt);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        reset = 1'b1;
        clear_drv();
        repeat (2) @(negedge clk);
        checks++;
        if ({obs_out_valid, obs_out_eos, obs_outctrl_valid, obs_ctrl_ready} !== 4'b0000 ||
            obs_out_data !== '0 || obs_in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got v=%b eos=%b data=%h ctrl=%b inrdy=%b outctrl=%b required all 0",
                     obs_out_valid, obs_out_eos, obs_out_data, obs_ctrl_ready, obs_in_ready, obs_outctrl_valid);
        end
        reset = 1'b0;
    endtask

    task automatic run_t1();
        for (int i = 0; i < 4; i++) tok_q[i].delete();
        push_tok(0, 1'b0, 16'd1); push_tok(0, 1'b0, 16'd2); push_tok(0, 1'b1, 16'd0);
        push_tok(1, 1'b0, 16'd10); push_tok(1, 1'b1, 16'd0);
        build_model(2);
        run_stream(200);
        checks++;
        if (out_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL t1_count got %0d required %0d", out_log.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < out_log.size(); k++) begin
            checks++;
            if (out_log[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL t1_token[%0d] got %h required %h", k, out_log[k], exp_q[k]);
            end
        end
`ifdef STREAM_MERGE_SRC_TAG_EN
        for (int k = 0; k < exp_src.size() && k < src_log.size(); k++) begin
            checks++;
            if (int'(src_log[k]) != exp_src[k]) begin
                errors++;
                $display("FAIL t6_src[%0d] got %0d required %0d", k, src_log[k], exp_src[k]);
            end
        end
`endif
    endtask

    task automatic test_basic();
        int n_out;
        sel = 1'b0;
        valid_pct = 100;
        ready_mode = 0;
        apply_reset();
        run_t1();
        n_out = out_log.size();
        drv_ctrl_valid = 1'b1;
        repeat (4) step();
        drv_ctrl_valid = 1'b0;
        checks++;
        if (ctrl_cnt != 1 || out_log.size() != n_out) begin
            errors++;
            $display("FAIL done_hold got inctrl=%0d tokens=%0d required inctrl=1 tokens=%0d",
                     ctrl_cnt, out_log.size(), n_out);
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        valid_pct = 100;
        ready_mode = 1;
        apply_reset();
        run_t1();
    endtask

    task automatic test_fairness();
        int last [4];
        sel = 1'b1;
        valid_pct = 100;
        ready_mode = 2;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 5; s++) push_tok(i, 1'b0, W'(i * 256 + s + 1));
            push_tok(i, 1'b1, 16'd0);
            last[i] = -1;
        end
        build_model(4);
        run_stream(500);
        checks++;
        if (gnt_log.size() != exp_gnt.size()) begin
            errors++;
            $display("FAIL t3_grant_count got %0d required %0d", gnt_log.size(), exp_gnt.size());
        end
        for (int k = 0; k < exp_gnt.size() && k < gnt_log.size(); k++) begin
            checks++;
            if (gnt_log[k] != exp_gnt[k]) begin
                errors++;
                $display("FAIL t3_grant[%0d] got %0d required %0d", k, gnt_log[k], exp_gnt[k]);
            end
            if (last[gnt_log[k]] >= 0) begin
                checks++;
                if (k - last[gnt_log[k]] - 1 > 3) begin
                    errors++;
                    $display("FAIL t3_wait input %0d got %0d grants required <= 3",
                             gnt_log[k], k - last[gnt_log[k]] - 1);
                end
            end
            last[gnt_log[k]] = k;
        end
        for (int k = 0; k < exp_q.size() && k < out_log.size(); k++) begin
            checks++;
            if (out_log[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL t3_token[%0d] got %h required %h", k, out_log[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_early_eos();
        int g1;
        sel = 1'b0;
        valid_pct = 100;
        ready_mode = 0;
        apply_reset();
        push_tok(0, 1'b0, 16'd5); push_tok(0, 1'b0, 16'd6); push_tok(0, 1'b0, 16'd7);
        push_tok(0, 1'b1, 16'd0);
        push_tok(1, 1'b1, 16'd0); push_tok(1, 1'b0, 16'd99);
        build_model(2);
        run_stream(200);
        checks++;
        if (out_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL t4_count got %0d required %0d", out_log.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < out_log.size(); k++) begin
            checks++;
            if (out_log[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL t4_token[%0d] got %h required %h", k, out_log[k], exp_q[k]);
            end
        end
        g1 = 0;
        foreach (gnt_log[k]) if (gnt_log[k] == 1) g1++;
        checks++;
        if (g1 != 1 || tok_q[1].size() != 1) begin
            errors++;
            $display("FAIL t4_in1_grants got %0d (left %0d) required 1 (left 1)", g1, tok_q[1].size());
        end
    endtask

    task automatic test_empty();
        sel = 1'b1;
        valid_pct = 100;
        ready_mode = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) push_tok(i, 1'b1, 16'd0);
        build_model(4);
        run_stream(200);
        checks++;
        if (out_log.size() != 1 || exp_q.size() != 1 || out_log[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL lone_eos got %0d tokens first=%h required 1 token %h",
                     out_log.size(), (out_log.size() > 0) ? out_log[0] : {1'b0, {W{1'b0}}}, exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        sel = 1'b0;
        valid_pct = 100;
        ready_mode = 3;
        apply_reset();
        push_tok(0, 1'b0, 16'd42); push_tok(0, 1'b1, 16'd0);
        push_tok(1, 1'b1, 16'd0);
        drv_ctrl_valid = 1'b1;
        drive();
        cyc = 0;
        while (!obs_out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        repeat (2) step();
        checks++;
        if (!obs_out_valid || obs_out_data !== 16'd42) begin
            errors++;
            $display("FAIL t5_hold got v=%b data=%0d required v=1 data=42", obs_out_valid, obs_out_data);
        end
        reset = 1'b1;
        stall_pend = 1'b0;
        @(negedge clk);
        checks++;
        if ({obs_out_valid, obs_out_eos, obs_outctrl_valid, obs_ctrl_ready} !== 4'b0000 ||
            obs_out_data !== '0 || obs_in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL t5_reset got v=%b eos=%b data=%h ctrl=%b outctrl=%b required all 0",
                     obs_out_valid, obs_out_eos, obs_out_data, obs_ctrl_ready, obs_outctrl_valid);
        end
        reset = 1'b0;
        clear_drv();
        push_tok(0, 1'b0, 16'd77);
        push_tok(1, 1'b0, 16'd78);
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (obs_out_valid !== 1'b0 || obs_in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL t5_idle cycle %0d got v=%b inrdy=%b required v=0 inrdy=0",
                         k, obs_out_valid, obs_in_ready);
            end
        end
        ready_mode = 0;
        run_t1();
    endtask

    task automatic test_random();
        logic [W-1:0] ref_q [4][$];
        int s;
        for (int it = 0; it < 3; it++) begin
            sel = 1'b1;
            valid_pct = 60;
            ready_mode = 2;
            apply_reset();
            for (int i = 0; i < 4; i++) begin
                ref_q[i].delete();
                for (int c = 0; c < int'($urandom_range(0, 6)); c++) begin
                    push_tok(i, 1'b0, W'(i * 4096 + it * 16 + c));
                    ref_q[i].push_back(W'(i * 4096 + it * 16 + c));
                end
                push_tok(i, 1'b1, 16'd0);
            end
            run_stream(3000);
            for (int k = 0; k < out_log.size(); k++) begin
                checks++;
                if (out_log[k][W]) begin
                    if (k != out_log.size() - 1 || out_log[k][W-1:0] !== '0) begin
                        errors++;
                        $display("FAIL rand_eos at %0d of %0d data=%h required last with data 0",
                                 k, out_log.size(), out_log[k][W-1:0]);
                    end
                end else begin
                    s = int'(out_log[k][W-1:12]);
                    if (s > 3 || ref_q[s].size() == 0 || ref_q[s][0] !== out_log[k][W-1:0]) begin
                        errors++;
                        $display("FAIL rand_order token %0d got %h required next of source %0d",
                                 k, out_log[k][W-1:0], s);
                    end else begin
                        void'(ref_q[s].pop_front());
                    end
                end
            end
            checks++;
            if (ref_q[0].size() + ref_q[1].size() + ref_q[2].size() + ref_q[3].size() != 0 ||
                out_log.size() == 0 || !out_log[out_log.size() - 1][W]) begin
                errors++;
                $display("FAIL rand_complete got %0d tokens missing and final eos missing/present, required none missing and final eos",
                         ref_q[0].size() + ref_q[1].size() + ref_q[2].size() + ref_q[3].size());
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        valid_pct = 100;
        ready_mode = 0;
        clear_drv();
        test_reset();
        test_basic();
        test_backpressure();
        test_fairness();
        test_early_eos();
        test_empty();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
